circ_fifo_param: RTL and testbench

CIRC_FIFO_PARAM -- requirements
Module: circ_fifo_param

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_dpram.sv | 22 ++
 rtl/circ_fifo_param.sv | 86 ++++++++
 tb/tb_circ_fifo_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer-width derivation.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read on the same edge; a read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/circ_fifo_param.sv
// Circular FIFO with registered status flags and sticky error flags.
module circ_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          data_out,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       fifo_threshold,
  output logic                       fifo_almost_empty,
  output logic                       fifo_overflow,
  output logic                       fifo_underflow,
  output logic [ptr_w(DEPTH)-1:0]    fill_count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_PW = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_PW = PW'(AE_LEVEL);

  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic              rd_ok, wr_ok;
  logic              rd_seen;
  logic [DATA_W-1:0] ram_q;

  // Accept decisions use the registered flags; a read frees room for a write when full.
  always_comb begin
    rd_ok      = rd & ~fifo_empty;
    wr_ok      = wr & (~fifo_full | rd_ok);
    wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, wr_ok};
    rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, rd_ok};
    cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Pointers, registered status derived from next-state pointers, sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fill_count        <= '0;
      fifo_full         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_threshold    <= 1'b0;
      fifo_almost_empty <= 1'b1;
      fifo_overflow     <= 1'b0;
      fifo_underflow    <= 1'b0;
      rd_seen           <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr_nxt;
      rd_ptr            <= rd_ptr_nxt;
      fill_count        <= cnt_nxt;
      fifo_full         <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                           (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
      fifo_empty        <= (wr_ptr_nxt == rd_ptr_nxt);
      fifo_threshold    <= (cnt_nxt >= AF_PW);
      fifo_almost_empty <= (cnt_nxt <= AE_PW);
      if (wr && !wr_ok)  fifo_overflow <= 1'b1;
      else if (clr_err)  fifo_overflow <= 1'b0;
      if (rd && !rd_ok)  fifo_underflow <= 1'b1;
      else if (clr_err)  fifo_underflow <= 1'b0;
      rd_seen           <= rd_seen | rd_ok;
    end
  end

  // Storage has no reset, so data_out reads as zero until the first accepted read.
  assign data_out = rd_seen ? ram_q : '0;

  fifo_dpram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_circ_fifo_param.sv
// Self-checking bench for circ_fifo_param against a queue-based model.
module tb_circ_fifo_param;
  import fifo_pkg::*;
  localparam int DW = DEF_DATA_W;
  localparam int DP = DEF_DEPTH;
  localparam int PW = ptr_w(DP);
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          wr = 0, rd = 0, clr_err = 0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          fifo_full, fifo_empty, fifo_threshold, fifo_almost_empty;
  logic          fifo_overflow, fifo_underflow;
  logic [PW-1:0] fill_count;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_unf;

  always #5 clk = ~clk;

  circ_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in), .clr_err(clr_err),
    .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_threshold(fifo_threshold), .fifo_almost_empty(fifo_almost_empty),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
    .fill_count(fill_count)
  );

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return 1 time unit later.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
    logic rok, wok;
    wr = w; rd = r; data_in = d; clr_err = c;
    @(posedge clk);
    rok = r && (mq.size() > 0);
    wok = w && ((mq.size() < DP) || rok);
    if (rok) m_dout = mq.pop_front();
    if (wok) mq.push_back(d);
    if (w && !wok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && !rok) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    #1;
    wr = 0; rd = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    total++; if (fill_count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fill_count); end
    total++; if (fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b/%b exp=1/1", fifo_empty, fifo_almost_empty); end
    total++; if (fifo_full !== 1'b0 || fifo_threshold !== 1'b0) begin bad++; $display("FAIL reset_full got=%b/%b exp=0/0", fifo_full, fifo_threshold); end
    total++; if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0/0", fifo_overflow, fifo_underflow); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DP; i++) begin
      step(1, 0, DW'(i), 0);
      total++; if (fill_count !== PW'(i)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, fill_count, i); end
      total++; if (fifo_threshold !== (i >= AF)) begin bad++; $display("FAIL fill_thr i=%0d got=%b exp=%b", i, fifo_threshold, (i >= AF)); end
      total++; if (fifo_full !== (i == DP)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, fifo_full, (i == DP)); end
      total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf i=%0d got=%b exp=0", i, fifo_overflow); end
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 8'h11, 0);
    total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", fifo_overflow); end
    total++; if (fill_count !== PW'(DP)) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", fill_count, DP); end
    for (int i = 1; i <= DP; i++) begin
      step(0, 1, '0, 0);
      total++; if (data_out !== DW'(i) || data_out !== m_dout) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, DW'(i)); end
    end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_underflow();
    step(0, 1, '0, 0);
    total++; if (fifo_underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", fifo_underflow); end
    total++; if (data_out !== 8'h10) begin bad++; $display("FAIL unf_dout got=%h exp=10", data_out); end
    step(0, 0, '0, 1);
    total++; if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL clr_err got=%b/%b exp=0/0", fifo_overflow, fifo_underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DP; i++) step(1, 0, DW'(8'h20 + i), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, DW'(8'h40 + i), 0);
      total++; if (data_out !== m_dout) begin bad++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, data_out, m_dout); end
      total++; if (fill_count !== PW'(DP)) begin bad++; $display("FAIL b2b_count i=%0d got=%0d exp=%0d", i, fill_count, DP); end
      total++; if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL b2b_err i=%0d got=%b/%b exp=0/0", i, fifo_overflow, fifo_underflow); end
    end
  endtask

  task automatic test_empty_rw();
    for (int i = 0; i < DP; i++) begin
      step(0, 1, '0, 0);
      total++; if (data_out !== m_dout) begin bad++; $display("FAIL erw_drain i=%0d got=%h exp=%h", i, data_out, m_dout); end
    end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL erw_empty got=%b exp=1", fifo_empty); end
    step(1, 1, 8'h77, 0);
    total++; if (fifo_underflow !== 1'b1) begin bad++; $display("FAIL erw_unf got=%b exp=1", fifo_underflow); end
    total++; if (fill_count !== PW'(1) || fifo_empty !== 1'b0) begin bad++; $display("FAIL erw_count got=%0d/%b exp=1/0", fill_count, fifo_empty); end
    step(0, 1, '0, 1);
    total++; if (data_out !== 8'h77 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL erw_read got=%h/%b exp=77/0", data_out, fifo_underflow); end
  endtask

  task automatic test_random();
    logic w, r, c;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < ((i / 100) % 2 ? 35 : 65));
      r = ($urandom_range(0, 99) < ((i / 100) % 2 ? 65 : 35));
      c = ($urandom_range(0, 19) == 0);
      step(w, r, DW'($urandom), c);
      total++; if (data_out !== m_dout) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, data_out, m_dout); end
      total++; if (fill_count !== PW'(mq.size())) begin bad++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, fill_count, mq.size()); end
      total++; if (fifo_full !== (mq.size() == DP) || fifo_empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_fe i=%0d got=%b/%b exp=%b/%b", i, fifo_full, fifo_empty, (mq.size() == DP), (mq.size() == 0)); end
      total++; if (fifo_threshold !== (mq.size() >= AF) || fifo_almost_empty !== (mq.size() <= AE)) begin bad++; $display("FAIL rnd_lvl i=%0d got=%b/%b exp=%b/%b", i, fifo_threshold, fifo_almost_empty, (mq.size() >= AF), (mq.size() <= AE)); end
      total++; if (fifo_overflow !== m_ovf || fifo_underflow !== m_unf) begin bad++; $display("FAIL rnd_err i=%0d got=%b/%b exp=%b/%b", i, fifo_overflow, fifo_underflow, m_ovf, m_unf); end
    end
  endtask

  task automatic test_midreset();
    step(0, 0, '0, 1);
    while (mq.size() > 0) step(0, 1, '0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, DW'(8'h50 + i), 0);
    step(0, 1, '0, 0);
    step(1, 0, 8'h60, 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    total++; if (fill_count !== 0 || fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b1) begin bad++; $display("FAIL mrst_count got=%0d/%b/%b exp=0/1/1", fill_count, fifo_empty, fifo_almost_empty); end
    total++; if (data_out !== '0 || fifo_full !== 1'b0 || fifo_threshold !== 1'b0) begin bad++; $display("FAIL mrst_out got=%h/%b/%b exp=00/0/0", data_out, fifo_full, fifo_threshold); end
    total++; if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL mrst_err got=%b/%b exp=0/0", fifo_overflow, fifo_underflow); end
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    step(1, 0, 8'hA5, 0);
    step(0, 1, '0, 0);
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL mrst_first got=%h exp=a5", data_out); end
    total++; if (fifo_empty !== 1'b1 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL mrst_after got=%b/%b exp=1/0", fifo_empty, fifo_underflow); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_empty_rw();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
